// File: rtl/gb_rd_sched.sv
// gb_rd_sched: read-side scheduler for the global-buffer SRAM read
// controllers of the WeiFlg (0), Act (1) and ActFlg (2) streams.
// Tracks ready banks per stream and issues at most one registered one-cycle
// Rd_prepare pulse per cycle, round-robin between eligible streams.
// It also counts banks issued per layer and reports layer completion.
module gb_rd_sched #(
  parameter int CNT_W = 4,
  parameter int TOT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SRAM_config_start,
  input  logic [CNT_W-1:0] cfg_sram_num_0,
  input  logic [CNT_W-1:0] cfg_sram_num_1,
  input  logic [CNT_W-1:0] cfg_sram_num_2,
  input  logic [TOT_W-1:0] cfg_bank_total_0,
  input  logic [TOT_W-1:0] cfg_bank_total_1,
  input  logic [TOT_W-1:0] cfg_bank_total_2,
  input  logic             fill_done_0,
  input  logic             fill_done_1,
  input  logic             fill_done_2,
  input  logic             rd_done_0,
  input  logic             rd_done_1,
  input  logic             rd_done_2,
  output logic             Rd_prepare_WeiFlg,
  output logic             Rd_prepare_Act,
  output logic             Rd_prepare_ActFlg,
  output logic [1:0]       sched_state,
  output logic             layer_done,
  output logic             ovf_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Controller state
  state_t                    state_reg;
  logic [1:0]                rr_ptr_reg;
  logic [2:0]                prep_reg;
  logic                      layer_done_reg;
  logic                      ovf_err_reg;

  // Per-layer configuration captured at start
  logic [2:0][CNT_W-1:0]     num_reg;
  logic [2:0][TOT_W-1:0]     total_reg;

  // Per-stream bookkeeping
  logic [2:0][CNT_W-1:0]     rdy_cnt_reg;
  logic [2:0]                busy_reg;
  logic [2:0][TOT_W-1:0]     issued_reg;
  logic [2:0]                fin_reg;

  // Gathered input vectors, indexed by stream number
  logic [2:0][CNT_W-1:0]     cfg_num;
  logic [2:0][TOT_W-1:0]     cfg_total;
  logic [2:0]                fill_vec;
  logic [2:0]                rd_vec;

  // Per-stream combinational status
  logic [2:0]                elig;
  logic [2:0]                issued_all;
  logic [2:0]                fin_now;
  logic [2:0]                rdy_full;
  logic [2:0]                ovf_hit;
  logic [2:0]                grant;
  logic [1:0]                rr_next;
  logic                      active;

  assign cfg_num   = {cfg_sram_num_2, cfg_sram_num_1, cfg_sram_num_0};
  assign cfg_total = {cfg_bank_total_2, cfg_bank_total_1, cfg_bank_total_0};
  assign fill_vec  = {fill_done_2, fill_done_1, fill_done_0};
  assign rd_vec    = {rd_done_2, rd_done_1, rd_done_0};

  // fill_done / rd_done are only meaningful while a layer is in flight
  assign active = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stream
      // A stream may be prepared only while scheduling, with a bank ready,
      // its read controller idle and banks still left to issue this layer.
      assign elig[gi] = (state_reg == ST_RUN) &&
                        (rdy_cnt_reg[gi] != '0) &&
                        !busy_reg[gi] &&
                        (issued_reg[gi] < total_reg[gi]);
      assign issued_all[gi] = (issued_reg[gi] == total_reg[gi]);
      // Once draining, a stream is finished as soon as its reader is idle
      assign fin_now[gi]  = fin_reg[gi] | ~busy_reg[gi];
      assign rdy_full[gi] = (rdy_cnt_reg[gi] >= num_reg[gi]);
      // Overflow: a bank reported filled while the ready count cannot grow
      assign ovf_hit[gi]  = active && fill_vec[gi] && !grant[gi] && rdy_full[gi];
    end
  endgenerate

  // Round-robin arbiter: scan from rr_ptr upward (mod 3), first eligible wins
  always_comb begin
    grant = 3'b000;
    case (rr_ptr_reg)
      2'd1: begin
        if (elig[1])      grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
      end
      2'd2: begin
        if (elig[2])      grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
      end
      default: begin
        if (elig[0])      grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
      end
    endcase
  end

  // Pointer moves past the winner; it holds when nothing is granted
  always_comb begin
    rr_next = rr_ptr_reg;
    if (grant[0])      rr_next = 2'd1;
    else if (grant[1]) rr_next = 2'd2;
    else if (grant[2]) rr_next = 2'd0;
  end

  // Layer FSM with registered prepare / done / error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= 2'd0;
      prep_reg       <= 3'b000;
      layer_done_reg <= 1'b0;
      ovf_err_reg    <= 1'b0;
      num_reg        <= '0;
      total_reg      <= '0;
      fin_reg        <= 3'b000;
    end else begin
      prep_reg       <= 3'b000;
      layer_done_reg <= 1'b0;
      if (SRAM_config_start) begin
        // Start overrides everything: abort any layer and reload config
        state_reg   <= ST_RUN;
        rr_ptr_reg  <= 2'd0;
        ovf_err_reg <= 1'b0;
        num_reg     <= cfg_num;
        total_reg   <= cfg_total;
        for (int k = 0; k < 3; k++) begin
          fin_reg[k] <= (cfg_total[k] == '0);
        end
      end else begin
        if (|ovf_hit) begin
          ovf_err_reg <= 1'b1;
        end
        case (state_reg)
          ST_RUN: begin
            rr_ptr_reg <= rr_next;
            prep_reg   <= grant;
            if (&issued_all) begin
              state_reg <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            fin_reg <= fin_now;
            if (&fin_now) begin
              state_reg      <= ST_DONE;
              layer_done_reg <= 1'b1;
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Per-stream ready-bank, busy and issued counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_cnt_reg <= '0;
      busy_reg    <= 3'b000;
      issued_reg  <= '0;
    end else if (SRAM_config_start) begin
      rdy_cnt_reg <= '0;
      busy_reg    <= 3'b000;
      issued_reg  <= '0;
    end else if (active) begin
      for (int k = 0; k < 3; k++) begin
        // Fill and grant together cancel; a fill into a full counter saturates
        if (fill_vec[k] && !grant[k]) begin
          if (!rdy_full[k]) begin
            rdy_cnt_reg[k] <= rdy_cnt_reg[k] + 1'b1;
          end
        end else if (grant[k] && !fill_vec[k]) begin
          rdy_cnt_reg[k] <= rdy_cnt_reg[k] - 1'b1;
        end
        // A grant requires !busy, so set and clear never coincide
        if (grant[k]) begin
          busy_reg[k]   <= 1'b1;
          issued_reg[k] <= issued_reg[k] + 1'b1;
        end else if (rd_vec[k]) begin
          busy_reg[k] <= 1'b0;
        end
      end
    end
  end

  assign Rd_prepare_WeiFlg = prep_reg[0];
  assign Rd_prepare_Act    = prep_reg[1];
  assign Rd_prepare_ActFlg = prep_reg[2];
  assign sched_state       = state_reg;
  assign layer_done        = layer_done_reg;
  assign ovf_err           = ovf_err_reg;

endmodule
